display_source_scheduler: RTL and testbench

- Time-shares one seven_segment display between NUM_SOURCES counter/data sources, each NUM_SEGMENTS hex digits wide.
- Rotates round-robin with a fixed dwell time and inserts a short blank gap at each switch.
- Supports manual advance (a debounced button_down pulse) and a hold/pause level.
- Sits between the counter instances and seven_segment; the top level gates anodes with blank.

---
 rtl/display_source_scheduler.sv | 158 +++++++++++++++
 tb/tb_display_source_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_source_scheduler.sv
// Round-robin time-sharing of one seven-segment display between several digit sources,
// with a fixed dwell per source, an optional blank gap at each switch, manual advance and hold.
module display_source_scheduler #(
    parameter int NUM_SOURCES  = 4,
    parameter int NUM_SEGMENTS = 4,
    parameter int DWELL_CYCLES = 200_000_000,
    parameter int BLANK_CYCLES = 10_000_000,
    localparam int SELW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_SOURCES-1:0][NUM_SEGMENTS-1:0][3:0] src_encoded,
    input  logic [NUM_SOURCES-1:0][NUM_SEGMENTS-1:0]  src_digit_point,
    input  logic [NUM_SOURCES-1:0]                    src_valid,
    input  logic                                      next_req,
    input  logic                                      hold_req,
    output logic [NUM_SEGMENTS-1:0][3:0]              encoded,
    output logic [NUM_SEGMENTS-1:0]                   digit_point,
    output logic                                      blank,
    output logic [SELW-1:0]                           sel_index,
    output logic                                      switch_pulse
);

    localparam int DWW = $clog2(DWELL_CYCLES + 1);
    localparam int BLW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t                         state_q, state_d;
    logic [SELW-1:0]                sel_q, sel_d, pend_q, pend_d;
    logic [DWW-1:0]                 dwell_q, dwell_d;
    logic [BLW-1:0]                 gap_q, gap_d;
    logic [NUM_SEGMENTS-1:0][3:0]   enc_q, enc_d;
    logic [NUM_SEGMENTS-1:0]        dp_q, dp_d;
    logic                           blank_q, blank_d, pulse_q, pulse_d;
    logic [SELW:0]                  cand;
    logic                           expire;

    // Returns {found, index} of the first valid source at start+0 .. start+N-1 (mod N);
    // skip_start drops offset 0. Scanned high-to-low so the lowest offset wins.
    function automatic logic [SELW:0] find_valid(input logic [NUM_SOURCES-1:0] v,
                                                 input logic [SELW-1:0] start,
                                                 input logic skip_start);
        logic [SELW:0] r;
        int unsigned   idx;
        r = '0;
        for (int unsigned j = 0; j < NUM_SOURCES; j++) begin
            idx = (NUM_SOURCES - 1 - j) + 32'(start);
            if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
            if (v[idx[SELW-1:0]] && !(skip_start && (j == NUM_SOURCES - 1)))
                r = {1'b1, idx[SELW-1:0]};
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        dwell_d = dwell_q;
        gap_d   = gap_q;
        pulse_d = 1'b0;
        cand    = '0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                cand = find_valid(src_valid, '0, 1'b0);
                if (cand[SELW]) begin
                    state_d = SHOW;
                    sel_d   = cand[SELW-1:0];
                    dwell_d = '0;
                    pulse_d = 1'b1;
                end
            end
            SHOW: begin
                expire = !hold_req && (dwell_q == DWW'(DWELL_CYCLES - 1));
                if (next_req || expire || !src_valid[sel_q]) begin
                    cand = find_valid(src_valid, sel_q, 1'b1);
                    if (cand[SELW]) begin
                        if (BLANK_CYCLES == 0) begin
                            sel_d   = cand[SELW-1:0];
                            dwell_d = '0;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = BLANK;
                            pend_d  = cand[SELW-1:0];
                            gap_d   = '0;
                        end
                    end else if (src_valid[sel_q]) begin
                        dwell_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!hold_req) begin
                    dwell_d = dwell_q + DWW'(1);
                end
            end
            BLANK: begin
                // Pending may have gone invalid during the gap, so search again from it.
                if (gap_q == BLW'(BLANK_CYCLES - 1)) begin
                    cand = find_valid(src_valid, pend_q, 1'b0);
                    if (cand[SELW]) begin
                        state_d = SHOW;
                        sel_d   = cand[SELW-1:0];
                        dwell_d = '0;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + BLW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        blank_d = (state_d != SHOW);
        enc_d   = '0;
        dp_d    = '0;
        if (state_d == SHOW) begin
            enc_d = src_encoded[sel_d];
            dp_d  = src_digit_point[sel_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            pend_q  <= '0;
            dwell_q <= '0;
            gap_q   <= '0;
            enc_q   <= '0;
            dp_q    <= '0;
            blank_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            dwell_q <= dwell_d;
            gap_q   <= gap_d;
            enc_q   <= enc_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            pulse_q <= pulse_d;
        end
    end

    assign encoded      = enc_q;
    assign digit_point  = dp_q;
    assign blank        = blank_q;
    assign sel_index    = sel_q;
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Scoreboard bench for display_source_scheduler: a cycle-level reference model predicts each
// registered output set, and a separate monitor pops and compares after every clock edge.
module tb_display_source_scheduler;

    localparam int N   = 4;
    localparam int SEG = 4;
    localparam int DW  = 8;
    localparam int BL  = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [N-1:0][SEG-1:0][3:0] src_encoded;
    logic [N-1:0][SEG-1:0]     src_digit_point;
    logic [N-1:0]              src_valid;
    logic                      next_req;
    logic                      hold_req;
    logic [SEG-1:0][3:0]       encoded;
    logic [SEG-1:0]            digit_point;
    logic                      blank;
    logic [1:0]                sel_index;
    logic                      switch_pulse;

    always #5 clk = ~clk;

    display_source_scheduler #(
        .NUM_SOURCES (N),
        .NUM_SEGMENTS(SEG),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .src_encoded    (src_encoded),
        .src_digit_point(src_digit_point),
        .src_valid      (src_valid),
        .next_req       (next_req),
        .hold_req       (hold_req),
        .encoded        (encoded),
        .digit_point    (digit_point),
        .blank          (blank),
        .sel_index      (sel_index),
        .switch_pulse   (switch_pulse)
    );

    typedef struct {
        logic [15:0] enc;
        logic [3:0]  dp;
        logic        blank;
        logic [1:0]  sel;
        logic        pulse;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0 = idle, 1 = showing, 2 = blank gap.
    int m_mode = 0, m_sel = 0, m_pend = 0, m_elapsed = 0, m_gap = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int search(input logic [N-1:0] v, input int start, input int first_off);
        int idx;
        for (int off = first_off; off < N; off++) begin
            idx = (start + off) % N;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // Advance the model by one clock using the inputs now applied, queue the
    // predicted outputs, and move to the next falling edge.
    task automatic tick();
        exp_t e;
        int   c;
        logic pulse;
        pulse = 1'b0;
        if (reset) begin
            m_mode = 0; m_sel = 0; m_elapsed = 0; m_gap = 0;
        end else begin
            case (m_mode)
                0: begin
                    c = search(src_valid, 0, 0);
                    if (c >= 0) begin
                        m_sel = c; m_mode = 1; m_elapsed = 0; pulse = 1'b1;
                    end
                end
                1: begin
                    if (next_req || (!hold_req && m_elapsed == DW - 1) || !src_valid[m_sel[1:0]]) begin
                        c = search(src_valid, m_sel, 1);
                        if (c >= 0) begin
                            m_pend = c; m_gap = 0; m_mode = 2;
                        end else if (src_valid[m_sel[1:0]]) begin
                            m_elapsed = 0;
                        end else begin
                            m_mode = 0;
                        end
                    end else if (!hold_req) begin
                        m_elapsed++;
                    end
                end
                default: begin
                    if (m_gap == BL - 1) begin
                        c = search(src_valid, m_pend, 0);
                        if (c >= 0) begin
                            m_sel = c; m_mode = 1; m_elapsed = 0; pulse = 1'b1;
                        end else begin
                            m_mode = 0;
                        end
                    end else begin
                        m_gap++;
                    end
                end
            endcase
        end
        e.blank = (m_mode != 1);
        e.enc   = (m_mode == 1) ? src_encoded[m_sel[1:0]] : 16'h0;
        e.dp    = (m_mode == 1) ? src_digit_point[m_sel[1:0]] : 4'h0;
        e.sel   = m_sel[1:0];
        e.pulse = pulse;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("blank",        32'(blank),        32'(e.blank));
                chk("encoded",      32'(encoded),      32'(e.enc));
                chk("digit_point",  32'(digit_point),  32'(e.dp));
                chk("sel_index",    32'(sel_index),    32'(e.sel));
                chk("switch_pulse", 32'(switch_pulse), 32'(e.pulse));
            end
        end
    end

    initial begin : driver
        int          guard;
        int unsigned r;
        reset     = 1'b1;
        src_valid = '0;
        next_req  = 1'b0;
        hold_req  = 1'b0;
        for (int k = 0; k < N; k++) begin
            src_encoded[k]     = 16'(k * 16'h1010);
            src_digit_point[k] = 4'(1 << k);
        end

        // Reset and idle with nothing valid, then first source comes up.
        ticks(2);
        reset = 1'b0;
        ticks(6);
        src_valid = 4'b0101;
        ticks(3);

        // Full rotation with wrap.
        src_valid = 4'b1111;
        ticks(50);

        // Sparse valid set: source 2 must be skipped.
        src_valid = 4'b1011;
        ticks(45);

        // Hold, manual advance under hold, release.
        src_valid = 4'b1111;
        hold_req  = 1'b1;
        ticks(30);
        next_req = 1'b1;
        tick();
        next_req = 1'b0;
        ticks(12);
        hold_req = 1'b0;
        ticks(20);

        // Single valid source: no gap, no switch; then all invalid.
        src_valid = 4'b0100;
        ticks(25);
        next_req = 1'b1;
        tick();
        next_req = 1'b0;
        ticks(5);
        src_valid = 4'b0000;
        ticks(3);

        // Drop the shown source, then the pending one during the gap.
        src_valid = 4'b1111;
        guard = 0;
        while (!(m_mode == 1 && m_sel == 1) && guard < 100) begin
            tick();
            guard++;
        end
        if (!(m_mode == 1 && m_sel == 1)) begin
            errors++;
            $display("FAIL wait_show_sel1 timed out");
        end
        src_valid[1] = 1'b0;
        tick();
        src_valid[2] = 1'b0;
        ticks(6);

        // Asynchronous reset in the middle of a gap with a non-zero selection.
        src_valid = 4'b1111;
        guard = 0;
        while (!(m_mode == 2 && m_sel != 0) && guard < 100) begin
            tick();
            guard++;
        end
        if (!(m_mode == 2 && m_sel != 0)) begin
            errors++;
            $display("FAIL wait_blank timed out");
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_blank", 32'(blank),        32'd1);
        chk("async_rst_sel",   32'(sel_index),    32'd0);
        chk("async_rst_enc",   32'(encoded),      32'd0);
        chk("async_rst_pulse", 32'(switch_pulse), 32'd0);
        tick();
        reset = 1'b0;
        ticks(4);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) src_valid = 4'($urandom);
            next_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 24) == 0) hold_req = ~hold_req;
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 3);
                src_encoded[r[1:0]] = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                r = $urandom_range(0, 3);
                src_digit_point[r[1:0]] = 4'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset    = 1'b0;
        next_req = 1'b0;
        hold_req = 1'b0;

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
